// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned divide sequencer that borrows the
// shared CPU ALU (ADD for shift-add multiply, SUB for restoring division).
module alu_muldiv_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  input  logic [7:0] opa,
  input  logic [7:0] opb,
  input  logic [7:0] cpu_flags,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_hi,
  output logic [7:0] res_lo,
  output logic [7:0] res_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  output logic [7:0] alu_cpu_flags,
  input  logic [7:0] alu_c,
  input  logic [7:0] alu_flags
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_M_ADD = 3'd1,
    ST_M_SHF = 3'd2,
    ST_D_SHF = 3'd3,
    ST_D_SUB = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0110;
  localparam logic [3:0] OP_SUB = 4'b0111;

  function automatic logic [7:0] pack_flags(input logic sf, input logic zf,
                                            input logic [2:0] keep, input logic cf);
    return {2'b00, sf, zf, keep, cf};
  endfunction

  state_t     state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  // hi/lo double as remainder/quotient, opd as multiplicand/divisor, ext as carry/r8
  logic [7:0] hi_r, hi_nxt_s, lo_r, lo_nxt_s, opd_r, opd_nxt_s;
  logic       ext_r, ext_nxt_s, mode_r, mode_nxt_s, finish_s;
  logic [7:0] flg_r, flg_nxt_s;
  logic [7:0] res_hi_r, res_hi_nxt_s, res_lo_r, res_lo_nxt_s, res_flags_r, res_flags_nxt_s;
  logic       busy_r, busy_nxt_s, done_r, done_nxt_s;
  logic [7:0] alu_a_r, alu_a_nxt_s, alu_b_r, alu_b_nxt_s;
  logic [3:0] alu_op_r, alu_op_nxt_s;
  logic       unused_flags_s;

  assign unused_flags_s = ^alu_flags[7:1];

  // Next-state, datapath updates and next values of every registered output
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    hi_nxt_s        = hi_r;
    lo_nxt_s        = lo_r;
    opd_nxt_s       = opd_r;
    ext_nxt_s       = ext_r;
    mode_nxt_s      = mode_r;
    flg_nxt_s       = flg_r;
    res_hi_nxt_s    = res_hi_r;
    res_lo_nxt_s    = res_lo_r;
    res_flags_nxt_s = res_flags_r;
    finish_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          mode_nxt_s = mode;
          flg_nxt_s  = cpu_flags;
          cnt_nxt_s  = 3'd0;
          hi_nxt_s   = 8'h00;
          ext_nxt_s  = 1'b0;
          if (!mode) begin
            lo_nxt_s    = opb;
            opd_nxt_s   = opa;
            state_nxt_s = ST_M_ADD;
          end else if (opb != 8'h00) begin
            lo_nxt_s    = opa;
            opd_nxt_s   = opb;
            state_nxt_s = ST_D_SHF;
          end else begin
            res_hi_nxt_s    = opa;
            res_lo_nxt_s    = 8'hFF;
            res_flags_nxt_s = pack_flags(1'b1, 1'b0, cpu_flags[3:1], 1'b1);
            state_nxt_s     = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_M_ADD: begin
        if (lo_r[0]) begin
          {ext_nxt_s, hi_nxt_s} = {alu_flags[0], alu_c};
        end else begin
          ext_nxt_s = 1'b0;
        end
        state_nxt_s = ST_M_SHF;
      end
      ST_M_SHF: begin
        hi_nxt_s = {ext_r, hi_r[7:1]};
        lo_nxt_s = {hi_r[0], lo_r[7:1]};
        if (cnt_r == 3'd7) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = cnt_r + 3'd1;
          state_nxt_s = ST_M_ADD;
        end
      end
      ST_D_SHF: begin
        {ext_nxt_s, hi_nxt_s, lo_nxt_s} = {hi_r, lo_r, 1'b0};
        state_nxt_s = ST_D_SUB;
      end
      ST_D_SUB: begin
        // a set r8 means the shifted remainder already exceeds any 8-bit divisor
        if (ext_r || !alu_flags[0]) begin
          hi_nxt_s    = alu_c;
          lo_nxt_s[0] = 1'b1;
        end else begin
          hi_nxt_s = hi_r;
        end
        ext_nxt_s = 1'b0;
        if (cnt_r == 3'd7) begin
          finish_s    = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          cnt_nxt_s   = cnt_r + 3'd1;
          state_nxt_s = ST_D_SHF;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase

    if (finish_s) begin
      res_hi_nxt_s = hi_nxt_s;
      res_lo_nxt_s = lo_nxt_s;
      if (mode_r) begin
        res_flags_nxt_s = pack_flags(lo_nxt_s[7], lo_nxt_s == 8'h00, flg_r[3:1], 1'b0);
      end else begin
        res_flags_nxt_s = pack_flags(hi_nxt_s[7], {hi_nxt_s, lo_nxt_s} == 16'h0000,
                                     flg_r[3:1], hi_nxt_s != 8'h00);
      end
    end else begin
      res_hi_nxt_s = res_hi_nxt_s;
    end

    busy_nxt_s = (state_nxt_s != ST_IDLE);
    done_nxt_s = (state_nxt_s == ST_DONE);
    // ALU drive follows the state being entered so it is valid for that whole cycle
    if (state_nxt_s == ST_M_ADD) begin
      alu_a_nxt_s  = hi_nxt_s;
      alu_b_nxt_s  = opd_nxt_s;
      alu_op_nxt_s = OP_ADD;
    end else if (state_nxt_s == ST_D_SUB) begin
      alu_a_nxt_s  = hi_nxt_s;
      alu_b_nxt_s  = opd_nxt_s;
      alu_op_nxt_s = OP_SUB;
    end else begin
      alu_a_nxt_s  = 8'h00;
      alu_b_nxt_s  = 8'h00;
      alu_op_nxt_s = OP_NOP;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      hi_r        <= 8'h00;
      lo_r        <= 8'h00;
      opd_r       <= 8'h00;
      ext_r       <= 1'b0;
      mode_r      <= 1'b0;
      flg_r       <= 8'h00;
      res_hi_r    <= 8'h00;
      res_lo_r    <= 8'h00;
      res_flags_r <= 8'h00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      alu_a_r     <= 8'h00;
      alu_b_r     <= 8'h00;
      alu_op_r    <= OP_NOP;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hi_r        <= hi_nxt_s;
      lo_r        <= lo_nxt_s;
      opd_r       <= opd_nxt_s;
      ext_r       <= ext_nxt_s;
      mode_r      <= mode_nxt_s;
      flg_r       <= flg_nxt_s;
      res_hi_r    <= res_hi_nxt_s;
      res_lo_r    <= res_lo_nxt_s;
      res_flags_r <= res_flags_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      alu_a_r     <= alu_a_nxt_s;
      alu_b_r     <= alu_b_nxt_s;
      alu_op_r    <= alu_op_nxt_s;
    end
  end

  assign busy          = busy_r;
  assign done          = done_r;
  assign res_hi        = res_hi_r;
  assign res_lo        = res_lo_r;
  assign res_flags     = res_flags_r;
  assign alu_a         = alu_a_r;
  assign alu_b         = alu_b_r;
  assign alu_op        = alu_op_r;
  assign alu_cpu_flags = flg_r;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq: directed table, start-hold and mid-op reset
// sequences, then random operations against an arithmetic reference model.
module tb_alu_muldiv_seq;

  logic       clk = 1'b0;
  logic       rst_n, start, mode;
  logic [7:0] opa, opb, cpu_flags;
  logic       busy, done;
  logic [7:0] res_hi, res_lo, res_flags, alu_a, alu_b, alu_cpu_flags, alu_c, alu_flags;
  logic [3:0] alu_op;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       m;
    logic [7:0] a, b, f, hi, lo, fl;
  } vec_t;
  vec_t tbl[8];

  alu_muldiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .opa(opa), .opb(opb),
    .cpu_flags(cpu_flags), .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo),
    .res_flags(res_flags), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_cpu_flags(alu_cpu_flags), .alu_c(alu_c), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Shared ALU: ADD gives carry-out in CF, SUB gives borrow in CF; upper flag bits are noise
  always_comb begin
    alu_c     = 8'h00;
    alu_flags = {7'h55, 1'b0};
    case (alu_op)
      4'b0110: {alu_flags[0], alu_c} = {1'b0, alu_a} + {1'b0, alu_b};
      4'b0111: begin
        alu_c        = alu_a - alu_b;
        alu_flags[0] = (alu_a < alu_b);
      end
      default: alu_c = 8'h00;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic; returns {flags, hi, lo}
  function automatic logic [23:0] ref_model(input logic m, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] f);
    int p, q, r;
    logic [7:0] hi, lo, fl;
    if (!m) begin
      p  = int'(a) * int'(b);
      hi = p[15:8];
      lo = p[7:0];
      fl = {2'b00, hi[7], p == 0, f[3:1], hi != 8'h00};
    end else if (b == 8'h00) begin
      hi = a;
      lo = 8'hFF;
      fl = {2'b00, 1'b1, 1'b0, f[3:1], 1'b1};
    end else begin
      q  = int'(a) / int'(b);
      r  = int'(a) % int'(b);
      hi = r[7:0];
      lo = q[7:0];
      fl = {2'b00, lo[7], q == 0, f[3:1], 1'b0};
    end
    return {fl, hi, lo};
  endfunction

  task automatic do_op(input bit hold, input logic m, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] f, input logic [7:0] ehi, input logic [7:0] elo,
                       input logic [7:0] efl, input string nm);
    int lat, nbusy, exp_lat;
    logic [15:0] seen, exp_seen;
    mode = m; opa = a; opb = b; cpu_flags = f; start = 1'b1;
    exp_lat  = (m && b == 8'h00) ? 1 : 17;
    exp_seen = !m ? 16'h0041 : (b == 8'h00 ? 16'h0001 : 16'h0081);
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat = 1;
    nbusy = int'(busy);
    seen = 16'h0001 << alu_op;
    while (!done && lat < 40) begin
      mode = 1'($urandom); opa = 8'($urandom); opb = 8'($urandom); cpu_flags = 8'($urandom);
      @(posedge clk); #1;
      lat++;
      nbusy += int'(busy);
      seen |= 16'h0001 << alu_op;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " busy_cycles"}, 32'(nbusy), 32'(exp_lat));
    chk({nm, " res_hi"}, 32'(res_hi), 32'(ehi));
    chk({nm, " res_lo"}, 32'(res_lo), 32'(elo));
    chk({nm, " res_flags"}, 32'(res_flags), 32'(efl));
    chk({nm, " alu_ops"}, 32'(seen), 32'(exp_seen));
    chk({nm, " alu_cpu_flags"}, 32'(alu_cpu_flags), 32'(f));
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, 32'(done), 32'd0);
    chk({nm, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [23:0] r;
    logic        m;
    logic [7:0]  a, b, f;

    tbl[0] = '{1'b0, 8'd13,  8'd11,  8'h00, 8'h00, 8'h8F, 8'h00};
    tbl[1] = '{1'b0, 8'd255, 8'd255, 8'h00, 8'hFE, 8'h01, 8'h21};
    tbl[2] = '{1'b0, 8'd0,   8'd77,  8'h00, 8'h00, 8'h00, 8'h10};
    tbl[3] = '{1'b1, 8'd200, 8'd7,   8'h00, 8'h04, 8'h1C, 8'h00};
    tbl[4] = '{1'b1, 8'd255, 8'd200, 8'h00, 8'h37, 8'h01, 8'h00};
    tbl[5] = '{1'b1, 8'h5A,  8'd0,   8'h00, 8'h5A, 8'hFF, 8'h21};
    tbl[6] = '{1'b1, 8'd5,   8'd9,   8'h0E, 8'h05, 8'h00, 8'h1E};
    tbl[7] = '{1'b0, 8'd16,  8'd16,  8'hFF, 8'h01, 8'h00, 8'h0F};

    rst_n = 1'b1; start = 1'b0; mode = 1'b0; opa = 8'h00; opb = 8'h00; cpu_flags = 8'h00;
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset res", {8'h00, res_hi, res_lo, res_flags}, 32'd0);
    chk("reset alu", {alu_a, alu_b, alu_op, 4'h0}, 32'd0);
    chk("reset alu_cpu_flags", 32'(alu_cpu_flags), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(1'b0, tbl[i].m, tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].hi, tbl[i].lo, tbl[i].fl,
            $sformatf("tbl%0d", i));
    end

    // start held high: second request taken only in the IDLE cycle after done
    do_op(1'b1, 1'b0, 8'd13, 8'd11, 8'h2E, 8'h00, 8'h8F, 8'h0E, "held_first");
    do_op(1'b0, 1'b1, 8'd200, 8'd7, 8'h00, 8'h04, 8'h1C, 8'h00, "held_second");

    // asynchronous reset in the middle of a multiply
    mode = 1'b0; opa = 8'd13; opb = 8'd11; cpu_flags = 8'h2E; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    chk("midrst res", {8'h00, res_hi, res_lo, res_flags}, 32'd0);
    chk("midrst alu", {alu_a, alu_b, alu_op, 4'h0}, 32'd0);
    chk("midrst alu_cpu_flags", 32'(alu_cpu_flags), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 1'b0, 8'd13, 8'd11, 8'h00, 8'h00, 8'h8F, 8'h00, "after_reset");

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      a = (i % 10 == 0) ? 8'hFF : 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      f = 8'($urandom);
      r = ref_model(m, a, b, f);
      do_op(1'b0, m, a, b, f, r[15:8], r[7:0], r[23:16], $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Multi-cycle sequencer that runs 8x8 unsigned multiply and 8/8 unsigned divide by iterating the shared combinational ALU.
- Multiply is shift-add using ALU ADD; divide is restoring division using ALU SUB. Shifts are done in internal registers.
- Sits beside the CPU execute stage. It owns the ALU operand/op inputs only while busy; the execute-stage mux gives it the ALU when busy=1.
- Start/busy/done handshake; results held until the next accepted start.

Parameters:
- none; ALU width is fixed at 8 bits.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = MUL, 1 = DIV; sampled with start
- opa  in  8  multiplicand / dividend; sampled with start
- opb  in  8  multiplier / divisor; sampled with start
- cpu_flags  in  8  CPU flag register; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, high in the DONE state
- res_hi  out  8  MUL: product[15:8]; DIV: remainder
- res_lo  out  8  MUL: product[7:0]; DIV: quotient
- res_flags  out  8  result flags, same bit layout as the ALU flags output
- alu_a  out  8  to ALU a
- alu_b  out  8  to ALU b
- alu_op  out  4  to ALU op
- alu_cpu_flags  out  8  to ALU cpu_flags; carries the latched cpu_flags
- alu_c  in  8  from ALU c
- alu_flags  in  8  from ALU flags; bit0 = CF

Behaviour:
- Reset (asynchronous, immediate, valid mid-operation):
  - state = IDLE; all internal registers cleared.
  - busy = 0, done = 0, res_hi = res_lo = res_flags = 0.
  - alu_a = alu_b = 0, alu_op = 4'b0000, alu_cpu_flags = 0.
- States: IDLE, M_ADD, M_SHF, D_SHF, D_SUB, DONE. Iteration counter cnt is 3 bits.
- IDLE with start = 1:
  - Latch opa, opb, mode and cpu_flags (flg); set cnt = 0.
  - MUL: hi = 0, lo = opb, mcand = opa, cy = 0; go to M_ADD.
  - DIV with opb != 0: rem = 0, r8 = 0, quo = opa, dvs = opb; go to D_SHF.
  - DIV with opb == 0: go straight to DONE.
- M_ADD:
  - Drive alu_op = 4'b0110, alu_a = hi, alu_b = mcand.
  - If lo[0] = 1: {cy, hi} <= {alu_flags[0], alu_c}; otherwise cy <= 0.
  - Go to M_SHF.
- M_SHF:
  - hi <= {cy, hi[7:1]}; lo <= {hi[0], lo[7:1]}.
  - If cnt == 7, go to DONE; otherwise cnt++ and go to M_ADD.
- D_SHF:
  - {r8, rem, quo} <= {rem, quo, 1'b0}, a 17-bit left shift.
  - Go to D_SUB.
- D_SUB:
  - Drive alu_op = 4'b0111, alu_a = rem, alu_b = dvs.
  - If r8 = 1 or alu_flags[0] = 0: rem <= alu_c, quo[0] <= 1. Otherwise rem and quo are unchanged.
  - r8 <= 0.
  - If cnt == 7, go to DONE; otherwise cnt++ and go to D_SHF.
- Idle ALU drive: in IDLE, M_SHF, D_SHF and DONE, drive alu_a = alu_b = 0 and alu_op = 4'b0000. alu_cpu_flags = flg at all times.
- Result registers are written on the transition into DONE:
  - MUL: res_hi = hi, res_lo = lo.
  - DIV: res_hi = rem, res_lo = quo.
  - DIV by zero: res_hi = opa latch, res_lo = 8'hFF.
- res_flags fields:
  - [7:6] = 0.
  - [5] SF = res_lo[7] for DIV, res_hi[7] for MUL.
  - [4] ZF = (res_lo == 0) for DIV, ({hi, lo} == 0) for MUL.
  - [3], [2], [1] = flg[3], flg[2], flg[1], unchanged.
  - [0] CF = (hi != 0) for MUL, divide-by-zero for DIV.
- DONE: done = 1 for exactly one cycle, then go to IDLE.
- Latency:
  - Normal operation: 16 iteration cycles; DONE is entered on the 17th rising edge after the start-sample edge, i.e. the edge that samples start counts as edge 1.
  - Divide-by-zero: DONE is entered on the edge that samples start.
- start is ignored when state != IDLE, including in the DONE cycle. Inputs opa, opb, mode and cpu_flags may change freely while busy.
- Result outputs hold their value until overwritten in the next DONE; they are not cleared on start.

Test Plan:
- MUL 13 x 11 -> res_hi = 0x00, res_lo = 0x8F, CF = 0, ZF = 0; done exactly 17 cycles after start; busy high for 17 cycles.
- MUL 255 x 255 -> res_hi = 0xFE, res_lo = 0x01, CF = 1, SF = 1. MUL 0 x 77 -> result 0x0000, ZF = 1.
- DIV 200 / 7 -> res_lo = 0x1C, res_hi = 0x04, CF = 0. DIV 255 / 200 exercises the r8 path -> res_lo = 0x01, res_hi = 0x37.
- DIV 0x5A / 0 -> done on the cycle after start; res_lo = 0xFF, res_hi = 0x5A, CF = 1; no ALU op other than 0000 is driven.
- start = 1 held continuously with changing operands during an operation -> only the first request executes; the second is accepted in the IDLE cycle after the done pulse. cpu_flags = 0x2E at start -> res_flags[3:1] = 3'b111.
- rst_n low at cycle 5 of a MUL -> busy, done and results go to 0 immediately, without waiting for a clock; the next start after release runs a clean 17-cycle operation.
